// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues instruction-memory addresses and hands fetched words to decode with a skid register.
// Optional halt support is enabled by defining FETCH_SEQ_HALT_EN.
module fetch_sequencer #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [PC_W-1:0]  pc,
    input  logic [WIDTH-1:0] ins,
    output logic [WIDTH-1:0] if_ins,
    output logic [PC_W-1:0]  if_pc,
    output logic             if_valid,
    input  logic             if_ready,
    input  logic             branch_en,
    input  logic [PC_W-1:0]  branch_target
`ifdef FETCH_SEQ_HALT_EN
    ,
    input  logic             halt_req,
    output logic             halted
`endif
);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_HOLD,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   data_pc_q, data_pc_d;
    logic [WIDTH-1:0]  hold_ins_q, hold_ins_d;
    logic [PC_W-1:0]   hold_pc_q, hold_pc_d;
    logic [PC_W-1:0]   pc_inc;
    logic              halt_now;

`ifdef FETCH_SEQ_HALT_EN
    assign halt_now = halt_req;
    assign halted   = (state_q == S_HALT);
`else
    assign halt_now = 1'b0;
`endif

    assign pc     = fetch_pc_q;
    assign pc_inc = fetch_pc_q + PC_W'(1);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        data_pc_d  = data_pc_q;
        hold_ins_d = hold_ins_q;
        hold_pc_d  = hold_pc_q;
        if_valid   = 1'b0;
        if_ins     = '0;
        if_pc      = '0;

        case (state_q)
            S_FILL: begin
                if (halt_now) begin
                    state_d = S_HALT;
                end else begin
                    data_pc_d  = fetch_pc_q;
                    fetch_pc_d = pc_inc;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if_valid = 1'b1;
                if_ins   = ins;
                if_pc    = data_pc_q;
                if (if_ready) begin
                    if (halt_now) begin
                        state_d = S_HALT;
                    end else begin
                        data_pc_d  = fetch_pc_q;
                        fetch_pc_d = pc_inc;
                    end
                end else begin
                    // Park the shown word; keep pc so ins settles on the next word for release.
                    hold_ins_d = ins;
                    hold_pc_d  = data_pc_q;
                    data_pc_d  = fetch_pc_q;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if_valid = 1'b1;
                if_ins   = hold_ins_q;
                if_pc    = hold_pc_q;
                if (if_ready) begin
                    if (halt_now) begin
                        state_d = S_HALT;
                    end else begin
                        data_pc_d  = fetch_pc_q;
                        fetch_pc_d = pc_inc;
                        state_d    = S_RUN;
                    end
                end
            end
            S_HALT: begin
                if (!halt_now) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        // A redirect overrides halt and handshake in every state.
        if (branch_en) begin
            fetch_pc_d = branch_target;
            state_d    = S_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            fetch_pc_q <= '0;
            data_pc_q  <= '0;
            hold_ins_q <= '0;
            hold_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            data_pc_q  <= data_pc_d;
            hold_ins_q <= hold_ins_d;
            hold_pc_q  <= hold_pc_d;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch sequencer: the requesting end of the instruction-memory read port. It drives the 8-bit word address `pc` into the instruction fetch memory and receives `ins` one clock later. It presents each fetched word to decode with a valid/ready handshake, including a skid register for backpressure. It supports branch redirect, and sits between the instruction memory and the decode stage.

## Interface
- `WIDTH`, default 32: instruction word width.
- `PC_W`, default 8: address width (256-word instruction memory).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pc`  out  PC_W  word address to instruction memory; registered.
- `ins`  in  WIDTH  memory read data; equals mem[pc of previous cycle].
- `if_ins`  out  WIDTH  instruction to decode.
- `if_pc`  out  PC_W  address of `if_ins`.
- `if_valid`  out  1  `if_ins`/`if_pc` valid.
- `if_ready`  in  1  decode accepts when `if_valid & if_ready`.
- `branch_en`  in  1  redirect request, one-cycle pulse.
- `branch_target`  in  PC_W  redirect address.
- `halt_req`  in  1  (only with `FETCH_SEQ_HALT_EN`) stop fetching.
- `halted`  out  1  (only with `FETCH_SEQ_HALT_EN`) sequencer stopped.

## Operation
- Registers:
  - `pc`: address issued this cycle.
  - `pc_q`: address whose data is on `ins`.
  - `hold_ins`, `hold_pc`: skid copy.
  - `state`.
- FILL: no data available.
  - `if_valid`=0, `if_ins`=0, `if_pc`=0.
  - Next edge: `pc_q`<=`pc`, `pc`<=`pc`+1, go to RUN.
- RUN: output `if_ins`=`ins`, `if_pc`=`pc_q`, `if_valid`=1.
  - `if_ready`=1: `pc_q`<=`pc`, `pc`<=`pc`+1, stay in RUN.
  - `if_ready`=0: `hold_ins`<=`ins`, `hold_pc`<=`pc_q`, `pc_q`<=`pc`, `pc` held, go to HOLD.
- HOLD: output `hold_ins`/`hold_pc`, `if_valid`=1.
  - `pc` stays held, so `ins` stays mem[`pc_q`].
  - `if_ready`=1: `pc_q`<=`pc`, `pc`<=`pc`+1, go to RUN.
  - `if_ready`=0: stay in HOLD.
- Branch, any state, has priority over the handshake:
  - `pc`<=`branch_target`, go to FILL, skid contents discarded.
  - The word shown in the branch cycle counts as consumed only if `if_ready`=1.
- Priority order: reset > branch > halt > handshake.
- Address arithmetic is modulo 2^PC_W: 255+1 wraps to 0, with no flag.
- Each address is delivered exactly once, in order, between redirects; there are no duplicates and no drops under any `if_ready` pattern.
- Reset values: `pc`=0, `pc_q`=0, `hold_*`=0, state=FILL, `if_valid`=0, `if_ins`=0, `if_pc`=0, `halted`=0.

## Timing
- Memory read latency is fixed at 1 cycle; the sequencer never samples `ins` in the cycle an address is issued.
- Reset deasserted at cycle 0 (FILL, `pc`=0) gives the first word, `if_pc`=0, with `if_valid`=1 in cycle 1.
- `branch_en` in cycle B:
  - Cycle B+1: FILL, `pc`=target, `if_valid`=0.
  - Cycle B+2: `if_ins`=mem[target].
  - The penalty is exactly one bubble.
- Steady state with `if_ready`=1 delivers one word per cycle.
- A stall of any length costs zero bubbles on release.
- Reset asserted mid-stall or mid-FILL takes effect on that edge; skid contents are lost.

## Configuration
- `FETCH_SEQ_HALT_EN` defined:
  - Adds `halt_req`, `halted`, and a HALT state.
  - `halt_req`=1 in RUN/HOLD: the current output still waits for acceptance. After the handshake, the next state is HALT instead of advancing.
  - `halt_req`=1 in FILL: go directly to HALT.
  - In HALT: `if_valid`=0, `pc` frozen, `halted`=1.
  - Leave HALT to FILL at the current `pc` when `halt_req` drops, or to FILL at the target on `branch_en`.
- Not defined: ports and state are absent; the sequencer fetches continuously.

## Test plan
- Memory preloaded with mem[k]=k. Reset, then `if_ready`=1 -> cycle 1 `if_pc`=0; cycles 1..5 `if_ins`=0,1,2,3,4 consecutively.
- `if_ready` low for 3 cycles while `if_pc`=2 -> 2 held stable with `if_valid`=1; after release, 3,4 follow with no bubble and no duplicate.
- `branch_en` with target 0x80 at `if_pc`=4 -> next cycle `if_valid`=0; then `if_pc`=0x80, 0x81.
- Branch to 0xFE, `if_ready`=1 -> `if_pc` sequence FE, FF, 00, 01.
- `branch_en` during HOLD -> held word dropped; bubble; then the target word is delivered. Random `if_ready` across 500 cycles -> scoreboard shows in-order, lossless delivery.
- With `FETCH_SEQ_HALT_EN`: `halt_req` at `if_pc`=5 accepted -> `halted`=1, `if_valid`=0. Release -> after FILL, `if_pc`=6.
